// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl -- sequencer for an NREG-entry register-file datapath.
//
// After an accepted start the controller walks through:
//   INIT : writes each register once (wr_en one-hot, step 0..NREG-1)
//   GO   : PASSES sweeps over all registers; at step k it reads register k on
//          port A and register (k+1) mod NREG on port B, and writes register k
//   DONE : a single cycle with done=1, then back to IDLE
// abort returns to IDLE from any non-idle state without a done pulse.
// ERROR is a sticky flag. It is set by a start that arrives while a sequence
// is running, and it is cleared by the next accepted start.
//
// Optional feature: macro REG_SEQ_CTRL_STALL_EN adds a 'stall' input. While
// stall is high in INIT or GO, the sequencer freezes and the enables read 0.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   start     sequence request, accepted only in IDLE
//   abort     cancels a running sequence
//   stall     (REG_SEQ_CTRL_STALL_EN only) freezes INIT/GO progress
//   rd_enA    one-hot read enable, port A
//   rd_enB    one-hot read enable, port B
//   wr_en     one-hot write enable
//   busy      high whenever the state is not IDLE
//   pass_cnt  current GO pass index (0 outside GO)
//   done      one-cycle completion pulse
//   ERROR     sticky protocol-error flag
module reg_seq_ctrl #(
    parameter int NREG   = 5,
    parameter int PASSES = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
`ifdef REG_SEQ_CTRL_STALL_EN
    input  logic             stall,
`endif
    output logic [NREG-1:0]  rd_enA,
    output logic [NREG-1:0]  rd_enB,
    output logic [NREG-1:0]  wr_en,
    output logic             busy,
    output logic [CNT_W-1:0] pass_cnt,
    output logic             done,
    output logic             ERROR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_GO   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NREG - 1);
    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] step_reg, step_next;
    logic [CNT_W-1:0] pass_reg, pass_next;
    logic             error_reg, error_next;
    logic             hold;

    // Stall only freezes progress. A stall does not block the abort path or
    // the error path.
`ifdef REG_SEQ_CTRL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            step_reg  <= '0;
            pass_reg  <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            pass_reg  <= pass_next;
            error_reg <= error_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        pass_next  = pass_reg;
        error_next = error_reg;
        case (state_reg)
            S_IDLE: begin
                // A start together with abort is simply dropped.
                if (start && !abort) begin
                    state_next = S_INIT;
                    step_next  = '0;
                    pass_next  = '0;
                    error_next = 1'b0;
                end
            end
            default: begin
                // A start while running is flagged and otherwise ignored.
                if (start) begin
                    error_next = 1'b1;
                end
                if (abort) begin
                    state_next = S_IDLE;
                    step_next  = '0;
                    pass_next  = '0;
                end else begin
                    case (state_reg)
                        S_INIT: begin
                            if (!hold) begin
                                if (step_reg == LAST_STEP) begin
                                    state_next = S_GO;
                                    step_next  = '0;
                                end else begin
                                    step_next = step_reg + 1'b1;
                                end
                            end
                        end
                        S_GO: begin
                            if (!hold) begin
                                if (step_reg == LAST_STEP) begin
                                    step_next = '0;
                                    if (pass_reg == LAST_PASS) begin
                                        state_next = S_DONE;
                                    end else begin
                                        pass_next = pass_reg + 1'b1;
                                    end
                                end else begin
                                    step_next = step_reg + 1'b1;
                                end
                            end
                        end
                        S_DONE: begin
                            state_next = S_IDLE;
                            step_next  = '0;
                            pass_next  = '0;
                        end
                        default: begin
                            state_next = S_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    // Output decode. The outputs depend on registered state only, except that
    // the optional stall input gates the enables.
    always_comb begin
        logic in_init;
        logic in_go;
        in_init  = (state_reg == S_INIT) && !hold;
        in_go    = (state_reg == S_GO) && !hold;
        rd_enA   = '0;
        rd_enB   = '0;
        wr_en    = '0;
        for (int i = 0; i < NREG; i++) begin
            wr_en[i]  = (in_init || in_go) && (step_reg == CNT_W'(i));
            rd_enA[i] = in_go && (step_reg == CNT_W'(i));
            // Port B reads one register ahead, so bit i is driven at step i-1.
            // The last step wraps around and pairs with register 0.
            rd_enB[i] = in_go && (step_reg == CNT_W'((i + NREG - 1) % NREG));
        end
        busy     = (state_reg != S_IDLE);
        done     = (state_reg == S_DONE);
        ERROR    = error_reg;
        pass_cnt = (state_reg == S_GO) ? pass_reg : '0;
    end

endmodule
